// File: rtl/cnn_mul_pipe_hs.sv
// rtl/cnn_mul_pipe_hs.sv - pipelined integer multiplier with valid/ready flow control
//
// Computes p = din0 * din1 (unsigned or two's-complement per SIGNED), shifts the
// full product right by OUT_SHIFT and narrows it to dout_WIDTH, flagging ovf when
// the shifted value does not fit. Latency is NUM_STAGE cycles (1..8), one result
// per cycle, with a global stall: every stage holds while the output is blocked.
//
// Optional feature macro: CNN_MUL_SAT_EN
//   defined     - on ovf, dout saturates to the max/min of dout_WIDTH
//   not defined - dout takes the low dout_WIDTH bits of the shifted product
//
// Ports:
//   ap_clk   in   clock, rising edge
//   ap_rst   in   synchronous reset, active-high
//   in_vld   in   operand pair valid
//   in_rdy   out  operands accepted this cycle (combinational from out_vld/out_rdy)
//   din0     in   operand A, din0_WIDTH bits
//   din1     in   operand B, din1_WIDTH bits
//   out_vld  out  dout/ovf hold a result
//   out_rdy  in   consumer takes the result this cycle
//   dout     out  result, dout_WIDTH bits
//   ovf      out  result did not fit dout_WIDTH (qualified by out_vld)

module cnn_mul_pipe_hs #(
    parameter int din0_WIDTH = 11,
    parameter int din1_WIDTH = 9,
    parameter int dout_WIDTH = 20,
    parameter int NUM_STAGE  = 3,
    parameter int SIGNED     = 0,
    parameter int OUT_SHIFT  = 0
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  in_vld,
    output logic                  in_rdy,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  out_vld,
    input  logic                  out_rdy,
    output logic [dout_WIDTH-1:0] dout,
    output logic                  ovf
);

    localparam int PW = din0_WIDTH + din1_WIDTH;
    // One guard bit above the wider of PW/dout_WIDTH so the range test below
    // always has at least one bit to inspect above the result field.
    localparam int XW = ((PW > dout_WIDTH) ? PW : dout_WIDTH) + 1;

    logic                  en;
    logic [NUM_STAGE-1:0]  vld;
    logic [PW-1:0]         fin_p;
    logic [PW-1:0]         shp;
    logic [XW-1:0]         ext;
    logic [XW-1:0]         hi_part;
    logic                  nar_ovf;
    logic [dout_WIDTH-1:0] nar_dout;

    // Both operands are extended to PW bits first; the low PW bits of the
    // PW x PW product are then the exact product for either signedness.
    function automatic logic [PW-1:0] mul_full(input logic [din0_WIDTH-1:0] a,
                                               input logic [din1_WIDTH-1:0] b);
        logic [PW-1:0] ea;
        logic [PW-1:0] eb;
        if (SIGNED != 0) begin
            ea = {{din1_WIDTH{a[din0_WIDTH-1]}}, a};
            eb = {{din0_WIDTH{b[din1_WIDTH-1]}}, b};
        end else begin
            ea = {{din1_WIDTH{1'b0}}, a};
            eb = {{din0_WIDTH{1'b0}}, b};
        end
        return ea * eb;
    endfunction

    // Global stall: the whole pipe moves only when the output slot is free
    // or being drained this cycle.
    assign en      = !(out_vld && !out_rdy);
    assign in_rdy  = en;
    assign out_vld = vld[NUM_STAGE-1];

    // Datapath ahead of the final (output) stage. With one stage the product
    // is formed straight from the inputs; otherwise stage 0 registers the
    // operands and any further stages delay the full product.
    generate
        if (NUM_STAGE == 1) begin : g_comb
            assign fin_p = mul_full(din0, din1);
        end else begin : g_reg
            logic [din0_WIDTH-1:0] a_r;
            logic [din1_WIDTH-1:0] b_r;
            logic [PW-1:0]         p0;

            always_ff @(posedge ap_clk) begin
                if (ap_rst) begin
                    a_r <= '0;
                    b_r <= '0;
                end else if (en) begin
                    a_r <= din0;
                    b_r <= din1;
                end
            end

            assign p0 = mul_full(a_r, b_r);

            if (NUM_STAGE == 2) begin : g_direct
                assign fin_p = p0;
            end else begin : g_dly
                logic [PW-1:0] pr [NUM_STAGE-2];

                always_ff @(posedge ap_clk) begin
                    if (ap_rst) begin
                        for (int k = 0; k < NUM_STAGE - 2; k++) begin
                            pr[k] <= '0;
                        end
                    end else if (en) begin
                        pr[0] <= p0;
                        for (int k = 1; k < NUM_STAGE - 2; k++) begin
                            pr[k] <= pr[k-1];
                        end
                    end
                end

                assign fin_p = pr[NUM_STAGE-3];
            end
        end
    endgenerate

    // Shift, extend to XW bits, then test whether everything above the
    // result field is a pure sign/zero extension of it.
    always_comb begin
        if (SIGNED != 0) begin
            shp     = $signed(fin_p) >>> OUT_SHIFT;
            ext     = {{(XW-PW){shp[PW-1]}}, shp};
            hi_part = $signed(ext) >>> (dout_WIDTH - 1);
            nar_ovf = !((hi_part == '0) || (&hi_part));
        end else begin
            shp     = fin_p >> OUT_SHIFT;
            ext     = {{(XW-PW){1'b0}}, shp};
            hi_part = ext >> dout_WIDTH;
            nar_ovf = (hi_part != '0);
        end
        nar_dout = ext[dout_WIDTH-1:0];
`ifdef CNN_MUL_SAT_EN
        if (nar_ovf) begin
            if (SIGNED == 0) begin
                nar_dout = '1;
            end else if (ext[XW-1]) begin
                nar_dout = {1'b1, {(dout_WIDTH-1){1'b0}}};
            end else begin
                nar_dout = {1'b0, {(dout_WIDTH-1){1'b1}}};
            end
        end
`endif
    end

    // Valid chain and output stage. Bubbles travel with the data, so the
    // output registers load on every enabled cycle.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            vld  <= '0;
            dout <= '0;
            ovf  <= 1'b0;
        end else if (en) begin
            vld[0] <= in_vld;
            for (int i = 1; i < NUM_STAGE; i++) begin
                vld[i] <= vld[i-1];
            end
            dout <= nar_dout;
            ovf  <= nar_ovf;
        end
    end

endmodule

// File: tb/tb_cnn_mul_pipe_hs.sv
// tb/tb_cnn_mul_pipe_hs.sv - self-checking bench for cnn_mul_pipe_hs over five configurations

module tb_cnn_mul_pipe_hs;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_vld = 1'b0;
    logic        out_rdy = 1'b0;
    logic [10:0] din0 = '0;
    logic [8:0]  din1 = '0;

    wire  [4:0]  rdy;
    wire  [4:0]  vld;
    wire  [4:0]  ovf;
    wire  [19:0] d0;
    wire  [19:0] d1;
    wire  [7:0]  d2;
    wire  [11:0] d3;
    wire  [19:0] d4;

    always #5 clk = ~clk;

    // Per-instance configuration: signed, A width, B width, out width, shift, stages
    int cs [5] = '{0, 0, 1, 0, 1};
    int wa [5] = '{11, 11, 8, 11, 11};
    int wb [5] = '{9, 9, 8, 9, 9};
    int wd [5] = '{20, 20, 8, 12, 20};
    int sh [5] = '{0, 0, 0, 4, 4};
    int ns [5] = '{3, 1, 3, 2, 4};

    cnn_mul_pipe_hs #(.din0_WIDTH(11), .din1_WIDTH(9), .dout_WIDTH(20),
                      .NUM_STAGE(3), .SIGNED(0), .OUT_SHIFT(0)) u0 (
        .ap_clk(clk), .ap_rst(rst), .in_vld(in_vld), .in_rdy(rdy[0]),
        .din0(din0), .din1(din1), .out_vld(vld[0]), .out_rdy(out_rdy),
        .dout(d0), .ovf(ovf[0]));

    cnn_mul_pipe_hs #(.din0_WIDTH(11), .din1_WIDTH(9), .dout_WIDTH(20),
                      .NUM_STAGE(1), .SIGNED(0), .OUT_SHIFT(0)) u1 (
        .ap_clk(clk), .ap_rst(rst), .in_vld(in_vld), .in_rdy(rdy[1]),
        .din0(din0), .din1(din1), .out_vld(vld[1]), .out_rdy(out_rdy),
        .dout(d1), .ovf(ovf[1]));

    cnn_mul_pipe_hs #(.din0_WIDTH(8), .din1_WIDTH(8), .dout_WIDTH(8),
                      .NUM_STAGE(3), .SIGNED(1), .OUT_SHIFT(0)) u2 (
        .ap_clk(clk), .ap_rst(rst), .in_vld(in_vld), .in_rdy(rdy[2]),
        .din0(din0[7:0]), .din1(din1[7:0]), .out_vld(vld[2]), .out_rdy(out_rdy),
        .dout(d2), .ovf(ovf[2]));

    cnn_mul_pipe_hs #(.din0_WIDTH(11), .din1_WIDTH(9), .dout_WIDTH(12),
                      .NUM_STAGE(2), .SIGNED(0), .OUT_SHIFT(4)) u3 (
        .ap_clk(clk), .ap_rst(rst), .in_vld(in_vld), .in_rdy(rdy[3]),
        .din0(din0), .din1(din1), .out_vld(vld[3]), .out_rdy(out_rdy),
        .dout(d3), .ovf(ovf[3]));

    cnn_mul_pipe_hs #(.din0_WIDTH(11), .din1_WIDTH(9), .dout_WIDTH(20),
                      .NUM_STAGE(4), .SIGNED(1), .OUT_SHIFT(4)) u4 (
        .ap_clk(clk), .ap_rst(rst), .in_vld(in_vld), .in_rdy(rdy[4]),
        .din0(din0), .din1(din1), .out_vld(vld[4]), .out_rdy(out_rdy),
        .dout(d4), .ovf(ovf[4]));

    // Reference pipe: one slot per stage, shifted as a whole when the output is free
    bit          mv [5][8];
    logic [63:0] md [5][8];
    logic        mo [5][8];

    int   n_vec = 0;
    int   n_err = 0;
    int   pops0 = 0;
    logic last_rdy0;
    logic last_vld0;

    function automatic logic [63:0] gd(input int k);
        case (k)
            0:       return {44'd0, d0};
            1:       return {44'd0, d1};
            2:       return {56'd0, d2};
            3:       return {52'd0, d3};
            default: return {44'd0, d4};
        endcase
    endfunction

    // Integer arithmetic straight from the rules: interpret, multiply,
    // floor-shift, range-test, then wrap or clamp.
    function automatic void refm(input int k, input logic [10:0] a, input logic [8:0] b,
                                 output logic [63:0] d, output logic o);
        longint av, bv, s, lo, hi, v;
        av = longint'(a) & ((longint'(1) << wa[k]) - 1);
        bv = longint'(b) & ((longint'(1) << wb[k]) - 1);
        if (cs[k] != 0) begin
            if (av >= (longint'(1) << (wa[k] - 1))) av = av - (longint'(1) << wa[k]);
            if (bv >= (longint'(1) << (wb[k] - 1))) bv = bv - (longint'(1) << wb[k]);
            lo = -(longint'(1) << (wd[k] - 1));
            hi = (longint'(1) << (wd[k] - 1)) - 1;
        end else begin
            lo = 0;
            hi = (longint'(1) << wd[k]) - 1;
        end
        s = (av * bv) >>> sh[k];
        o = (s < lo) || (s > hi);
        v = s;
`ifdef CNN_MUL_SAT_EN
        if (s < lo) v = lo;
        else if (s > hi) v = hi;
`endif
        d = 64'(v) & ((64'd1 << wd[k]) - 1);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int k = 0; k < 5; k++) begin
            for (int j = 0; j < 8; j++) begin
                mv[k][j] = 1'b0;
                md[k][j] = '0;
                mo[k][j] = 1'b0;
            end
        end
    endtask

    // One clock: drive, check all instances at the falling edge, advance model.
    task automatic cycle(input logic v, input logic [10:0] a, input logic [8:0] b, input logic r);
        logic [63:0] nd;
        logic        no;
        in_vld  = v;
        din0    = a;
        din1    = b;
        out_rdy = r;
        @(negedge clk);
        last_rdy0 = rdy[0];
        last_vld0 = vld[0];
        if (vld[0] && r) pops0++;
        for (int k = 0; k < 5; k++) begin
            int n;
            bit ev;
            n  = ns[k];
            ev = mv[k][n-1];
            chk($sformatf("out_vld[%0d]", k), {63'd0, vld[k]}, {63'd0, ev});
            chk($sformatf("in_rdy[%0d]", k), {63'd0, rdy[k]}, {63'd0, !(ev && !r)});
            if (ev) begin
                chk($sformatf("dout[%0d]", k), gd(k), md[k][n-1]);
                chk($sformatf("ovf[%0d]", k), {63'd0, ovf[k]}, {63'd0, mo[k][n-1]});
            end
        end
        for (int k = 0; k < 5; k++) begin
            int n;
            n = ns[k];
            if (!(mv[k][n-1] && !r)) begin
                for (int j = n - 1; j > 0; j--) begin
                    mv[k][j] = mv[k][j-1];
                    md[k][j] = md[k][j-1];
                    mo[k][j] = mo[k][j-1];
                end
                refm(k, a, b, nd, no);
                mv[k][0] = v;
                md[k][0] = nd;
                mo[k][0] = no;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        in_vld  = 1'b0;
        out_rdy = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_model();
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("rst_out_vld[%0d]", k), {63'd0, vld[k]}, 64'd0);
            chk($sformatf("rst_in_rdy[%0d]", k), {63'd0, rdy[k]}, 64'd1);
            chk($sformatf("rst_dout[%0d]", k), gd(k), 64'd0);
            chk($sformatf("rst_ovf[%0d]", k), {63'd0, ovf[k]}, 64'd0);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 11'd0, 9'd0, 1'b1);
    endtask

    initial begin
        clear_model();
        do_reset();

        // Max unsigned operands through the default and single-stage builds
        cycle(1'b1, 11'd2047, 9'd511, 1'b1);
        chk("s1_out_vld", {63'd0, vld[1]}, 64'd1);
        chk("s1_dout", {44'd0, d1}, 64'd1046017);
        idle(2);
        chk("dflt_out_vld", {63'd0, vld[0]}, 64'd1);
        chk("dflt_dout", {44'd0, d0}, 64'd1046017);
        chk("dflt_ovf", {63'd0, ovf[0]}, 64'd0);
        idle(6);

        // -128 * -1 into a signed 8-bit result
        cycle(1'b1, 11'h080, 9'h0FF, 1'b1);
        idle(2);
        chk("neg128_out_vld", {63'd0, vld[2]}, 64'd1);
        chk("neg128_ovf", {63'd0, ovf[2]}, 64'd1);
`ifdef CNN_MUL_SAT_EN
        chk("neg128_dout", {56'd0, d2}, 64'd127);
`else
        chk("neg128_dout", {56'd0, d2}, 64'd128);
`endif
        idle(6);

        // Shifted results: 100*50>>4 unsigned, -100*50>>>4 signed
        cycle(1'b1, 11'd100, 9'd50, 1'b1);
        cycle(1'b1, 11'd1948, 9'd50, 1'b1);
        chk("shift_u_out_vld", {63'd0, vld[3]}, 64'd1);
        chk("shift_u_dout", {52'd0, d3}, 64'd312);
        idle(3);
        chk("shift_s_out_vld", {63'd0, vld[4]}, 64'd1);
        chk("shift_s_dout", {44'd0, d4}, 64'hFFEC7);
        chk("shift_s_ovf", {63'd0, ovf[4]}, 64'd0);
        idle(6);

        // 16 back-to-back random pairs
        pops0 = 0;
        for (int i = 0; i < 16; i++) cycle(1'b1, 11'($urandom), 9'($urandom), 1'b1);
        idle(4);
        chk("b2b_pop_count", 64'(pops0), 64'd16);
        idle(4);

        // Full pipe stalled for 5 cycles, then released with push and pop together
        for (int i = 0; i < 6; i++) cycle(1'b1, 11'($urandom), 9'($urandom), 1'b1);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 11'($urandom), 9'($urandom), 1'b0);
            chk("stall_in_rdy", {63'd0, last_rdy0}, 64'd0);
            chk("stall_out_vld", {63'd0, last_vld0}, 64'd1);
        end
        cycle(1'b1, 11'($urandom), 9'($urandom), 1'b1);
        chk("release_in_rdy", {63'd0, last_rdy0}, 64'd1);
        chk("release_out_vld", {63'd0, last_vld0}, 64'd1);
        idle(6);

        // Reset with three results in flight; nothing stale may follow
        for (int i = 0; i < 3; i++) cycle(1'b1, 11'($urandom), 9'($urandom), 1'b1);
        do_reset();
        idle(6);

        // Random traffic with random back-pressure
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0, 11'($urandom), 9'($urandom),
                  $urandom_range(0, 3) != 0);
        end
        idle(8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
